// File: rtl/aud_defs.sv
// Shared definitions for the AUD Branch Trace Mode receive path.
// Holds the header size codes and their nibble-count lookup, the
// message type codes, and the deframer state encoding.
package aud_defs;

  // Header size code (header[1:0]) -> number of address nibbles
  localparam logic [1:0] AUD_BTM_SZ_NIB = 2'b00;  // 1 nibble
  localparam logic [1:0] AUD_BTM_SZ_1B  = 2'b01;  // 2 nibbles
  localparam logic [1:0] AUD_BTM_SZ_2B  = 2'b10;  // 4 nibbles
  localparam logic [1:0] AUD_BTM_SZ_4B  = 2'b11;  // 8 nibbles

  // Message type codes (header[3:2])
  localparam logic [1:0] AUD_BTM_TYPE_0 = 2'b00;
  localparam logic [1:0] AUD_BTM_TYPE_1 = 2'b01;
  localparam logic [1:0] AUD_BTM_TYPE_2 = 2'b10;
  localparam logic [1:0] AUD_BTM_TYPE_3 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } aud_state_e;

  function automatic logic [3:0] aud_nib_count(input logic [1:0] size);
    case (size)
      AUD_BTM_SZ_NIB: aud_nib_count = 4'd1;
      AUD_BTM_SZ_1B:  aud_nib_count = 4'd2;
      AUD_BTM_SZ_2B:  aud_nib_count = 4'd4;
      default:        aud_nib_count = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/aud_pin_sync.sv
// Multi-bit pin synchronizer with rising-edge detect on one selected bit.
// Every bit passes through g_stages flops; the selected bit also feeds a
// history flop so the edge pulse lines up with the synced bus value.
// Ports:
//   clk_sys_i  system clock
//   rst_n_i    asynchronous active-low reset (flops load g_rst_val)
//   d_i        asynchronous pin bus
//   q_o        synchronized bus (last sync stage)
//   rise_o     one-cycle pulse: q_o[g_edge_bit] went 0 -> 1
module aud_pin_sync #(
  parameter int                 g_width    = 1,
  parameter int                 g_stages   = 2,
  parameter int                 g_edge_bit = 0,
  parameter logic [g_width-1:0] g_rst_val  = '0
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  input  logic [g_width-1:0] d_i,
  output logic [g_width-1:0] q_o,
  output logic               rise_o
);

  logic [g_width-1:0] sync_q [g_stages];
  logic               hist_q;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_stages; i++) sync_q[i] <= g_rst_val;
      hist_q <= g_rst_val[g_edge_bit];
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < g_stages; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[g_stages-1][g_edge_bit];
    end
  end

  assign q_o    = sync_q[g_stages-1];
  assign rise_o = sync_q[g_stages-1][g_edge_bit] & ~hist_q;

endmodule

// File: rtl/aud_btm_rx.sv
// AUD Branch Trace Mode capture stage. Oversamples the AUD pins, deframes
// header + address nibbles into messages and hands each one to the trace
// FIFO writer through a single-entry valid/ready output register, counting
// messages that had to be dropped because the entry was still occupied.
// Ports:
//   clk_sys_i, rst_n_i         clock, async active-low reset
//   en_i                       capture enable; low forces IDLE
//   aud_ck_i/aud_data_i/aud_nsync_i  raw AUD pins
//   msg_valid_o/msg_ready_i    record handshake
//   msg_type_o/msg_size_o/msg_addr_o  record fields
//   ovf_o, drop_cnt_o, ovf_clr_i      drop accounting
//   trunc_o                    sticky early-header abort flag
//   idle_o                     IDLE with no pending record
// Optional: define AUD_BTM_RX_TSTAMP_EN to add msg_tstamp_o, a 32-bit
// free-running cycle count captured at each header.
module aud_btm_rx
  import aud_defs::*;
#(
  parameter int g_sync_stages = 2,
  parameter int g_drop_cnt_w  = 16
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    aud_ck_i,
  input  logic [3:0]              aud_data_i,
  input  logic                    aud_nsync_i,
  output logic                    msg_valid_o,
  input  logic                    msg_ready_i,
  output logic [1:0]              msg_type_o,
  output logic [1:0]              msg_size_o,
  output logic [31:0]             msg_addr_o,
  output logic                    ovf_o,
  input  logic                    ovf_clr_i,
  output logic [g_drop_cnt_w-1:0] drop_cnt_o,
  output logic                    trunc_o,
  output logic                    idle_o
`ifdef AUD_BTM_RX_TSTAMP_EN
  ,
  output logic [31:0]             msg_tstamp_o
`endif
);

  // Pin bus layout {ck, nsync, data}; ck and nsync idle high, data low.
  logic [5:0] pin_raw, pin_s;
  logic       evt, nsync_s;
  logic [3:0] nib_s;

  assign pin_raw = {aud_ck_i, aud_nsync_i, aud_data_i};

  aud_pin_sync #(
    .g_width   (6),
    .g_stages  (g_sync_stages),
    .g_edge_bit(5),
    .g_rst_val (6'b110000)
  ) u_pin_sync (
    .clk_sys_i(clk_sys_i),
    .rst_n_i  (rst_n_i),
    .d_i      (pin_raw),
    .q_o      (pin_s),
    .rise_o   (evt)
  );

  assign nsync_s = pin_s[4];
  assign nib_s   = pin_s[3:0];

  aud_state_e  state, state_nxt;
  logic [1:0]  hdr_type, hdr_size;
  logic [31:0] addr_sr, addr_nxt;
  logic [3:0]  nib_cnt;
  logic        latch_hdr, wr_nib, done, abort, drop;

  always_comb begin
    state_nxt = state;
    latch_hdr = 1'b0;
    wr_nib    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    if (!en_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (evt && !nsync_s) begin
            latch_hdr = 1'b1;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (evt && !nsync_s) begin
            latch_hdr = 1'b1;
            abort     = 1'b1;
          end else if (evt) begin
            wr_nib = 1'b1;
            if (nib_cnt + 4'd1 == aud_nib_count(hdr_size)) begin
              done      = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address with the current nibble merged in; the completing nibble goes
  // straight into the output register from here.
  always_comb begin
    addr_nxt = addr_sr;
    addr_nxt[{nib_cnt[2:0], 2'b00} +: 4] = nib_s;
  end

  assign drop = done & msg_valid_o & ~msg_ready_i;

`ifdef AUD_BTM_RX_TSTAMP_EN
  logic [31:0] ts_cnt, ts_hdr;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_cnt       <= '0;
      ts_hdr       <= '0;
      msg_tstamp_o <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (latch_hdr) ts_hdr <= ts_cnt;
      if (done && !drop) msg_tstamp_o <= ts_hdr;
    end
  end
`endif

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      hdr_type <= '0;
      hdr_size <= '0;
      addr_sr  <= '0;
      nib_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_hdr) begin
        hdr_type <= nib_s[3:2];
        hdr_size <= nib_s[1:0];
        addr_sr  <= '0;
        nib_cnt  <= '0;
      end else if (wr_nib) begin
        addr_sr <= addr_nxt;
        nib_cnt <= nib_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      msg_valid_o <= 1'b0;
      msg_type_o  <= '0;
      msg_size_o  <= '0;
      msg_addr_o  <= '0;
      ovf_o       <= 1'b0;
      drop_cnt_o  <= '0;
      trunc_o     <= 1'b0;
    end else begin
      // A completion in the same cycle as an accept simply refills the entry.
      if (done && !drop) begin
        msg_valid_o <= 1'b1;
        msg_type_o  <= hdr_type;
        msg_size_o  <= hdr_size;
        msg_addr_o  <= addr_nxt;
      end else if (msg_valid_o && msg_ready_i) begin
        msg_valid_o <= 1'b0;
      end

      // A drop coinciding with a clear counts as the first drop after it.
      if (drop) begin
        ovf_o <= 1'b1;
        if (ovf_clr_i)        drop_cnt_o <= {{(g_drop_cnt_w-1){1'b0}}, 1'b1};
        else if (!(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o      <= 1'b0;
        drop_cnt_o <= '0;
      end

      if (abort)          trunc_o <= 1'b1;
      else if (ovf_clr_i) trunc_o <= 1'b0;
    end
  end

  assign idle_o = (state == ST_IDLE) & ~msg_valid_o;

endmodule

// File: tb/tb_aud_btm_rx.sv
module tb_aud_btm_rx;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        aud_ck = 1'b1;
  logic [3:0]  aud_data = 4'h0;
  logic        aud_nsync = 1'b1;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic [1:0]  msg_type, msg_size;
  logic [31:0] msg_addr;
  logic        ovf, ovf_clr = 1'b0, trunc, idle;
  logic [15:0] drop_cnt;
`ifdef AUD_BTM_RX_TSTAMP_EN
  logic [31:0] msg_tstamp;
`endif

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  logic [1:0]  q_type[$];
  logic [1:0]  q_size[$];
  logic [31:0] q_addr[$];

  always #5 clk_sys = ~clk_sys;

  aud_btm_rx #(.g_sync_stages(2), .g_drop_cnt_w(16)) dut (
    .clk_sys_i  (clk_sys),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .aud_ck_i   (aud_ck),
    .aud_data_i (aud_data),
    .aud_nsync_i(aud_nsync),
    .msg_valid_o(msg_valid),
    .msg_ready_i(msg_ready),
    .msg_type_o (msg_type),
    .msg_size_o (msg_size),
    .msg_addr_o (msg_addr),
    .ovf_o      (ovf),
    .ovf_clr_i  (ovf_clr),
    .drop_cnt_o (drop_cnt),
    .trunc_o    (trunc),
    .idle_o     (idle)
`ifdef AUD_BTM_RX_TSTAMP_EN
    ,
    .msg_tstamp_o(msg_tstamp)
`endif
  );

  // Inputs only change just after a rising edge, so the falling edge sees
  // the values that the next rising edge will act on.
  always @(negedge clk_sys) begin
    if (msg_valid) vcnt <= vcnt + 1;
    if (msg_valid && msg_ready && rst_n) begin
      q_type.push_back(msg_type);
      q_size.push_back(msg_size);
      q_addr.push_back(msg_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_nib(input logic ns, input logic [3:0] n);
    aud_ck = 1'b0;
    aud_data = n;
    aud_nsync = ns;
    cyc(3);
    aud_ck = 1'b1;
    cyc(3);
  endtask

  task automatic clr_q();
    q_type.delete();
    q_size.delete();
    q_addr.delete();
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] t, input logic [1:0] s,
                         input logic [31:0] a);
    chk({tag, "_avail"}, (q_addr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (q_addr.size() > 0) begin
      chk({tag, "_type"}, {30'd0, q_type.pop_front()}, {30'd0, t});
      chk({tag, "_size"}, {30'd0, q_size.pop_front()}, {30'd0, s});
      chk({tag, "_addr"}, q_addr.pop_front(), a);
    end
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", {31'd0, msg_valid}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_addr", msg_addr, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_trunc", {31'd0, trunc}, 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // 8-nibble frame, ready held high
    msg_ready = 1'b1;
    clr_q();
    vcnt = 0;
    send_nib(1'b0, 4'h3);
    for (int i = 1; i <= 8; i++) send_nib(1'b1, 4'(i));
    cyc(10);
    pop_chk("t1", 2'd0, 2'd3, 32'h8765_4321);
    chk("t1_qempty", q_addr.size(), 32'd0);
    chk("t1_vcycles", vcnt, 32'd1);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // held record, second completion dropped, clear
    msg_ready = 1'b0;
    send_nib(1'b0, 4'h4);
    send_nib(1'b1, 4'hA);
    cyc(10);
    chk("t2_valid", {31'd0, msg_valid}, 32'd1);
    chk("t2_addr", msg_addr, 32'h0000_000A);
    chk("t2_type", {30'd0, msg_type}, 32'd1);
    chk("t2_size", {30'd0, msg_size}, 32'd0);
    chk("t2_idle_busy", {31'd0, idle}, 32'd0);
    send_nib(1'b0, 4'h4);
    send_nib(1'b1, 4'h5);
    cyc(10);
    chk("t2_drop", {16'd0, drop_cnt}, 32'd1);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_hold", msg_addr, 32'h0000_000A);
    pulse_clr();
    chk("t2_ovf_clr", {31'd0, ovf}, 32'd0);
    chk("t2_drop_clr", {16'd0, drop_cnt}, 32'd0);
    clr_q();
    msg_ready = 1'b1;
    cyc(4);
    pop_chk("t2_drain", 2'd1, 2'd0, 32'h0000_000A);
    chk("t2_qempty", q_addr.size(), 32'd0);

    // early header restarts the frame
    send_nib(1'b0, 4'h2);
    send_nib(1'b1, 4'h1);
    send_nib(1'b1, 4'h2);
    send_nib(1'b0, 4'h1);
    send_nib(1'b1, 4'hF);
    send_nib(1'b1, 4'hE);
    cyc(10);
    chk("t3_trunc", {31'd0, trunc}, 32'd1);
    pop_chk("t3", 2'd0, 2'd1, 32'h0000_00EF);
    chk("t3_qempty", q_addr.size(), 32'd0);
    pulse_clr();
    chk("t3_trunc_clr", {31'd0, trunc}, 32'd0);

    // accept and completion in the same cycle
    msg_ready = 1'b0;
    send_nib(1'b0, 4'h0);
    send_nib(1'b1, 4'h3);
    cyc(6);
    send_nib(1'b0, 4'h4);
    aud_ck = 1'b0;
    aud_data = 4'h9;
    aud_nsync = 1'b1;
    cyc(3);
    aud_ck = 1'b1;
    cyc(2);
    msg_ready = 1'b1;
    cyc(8);
    pop_chk("t4_a", 2'd0, 2'd0, 32'h0000_0003);
    pop_chk("t4_b", 2'd1, 2'd0, 32'h0000_0009);
    chk("t4_drop", {16'd0, drop_cnt}, 32'd0);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);

    // async reset in the middle of a frame with a record pending
    msg_ready = 1'b0;
    send_nib(1'b0, 4'h8);
    send_nib(1'b1, 4'h6);
    send_nib(1'b0, 4'h3);
    send_nib(1'b1, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, msg_valid}, 32'd0);
    chk("t5_addr", msg_addr, 32'd0);
    chk("t5_type", {30'd0, msg_type}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    msg_ready = 1'b1;
    clr_q();
    send_nib(1'b0, 4'h4);
    send_nib(1'b1, 4'hC);
    cyc(10);
    pop_chk("t5_post", 2'd1, 2'd0, 32'h0000_000C);

    // enable dropped mid-frame, headerless nibbles afterwards
    send_nib(1'b0, 4'h2);
    send_nib(1'b1, 4'h1);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    for (int i = 3; i <= 6; i++) send_nib(1'b1, 4'(i));
    cyc(10);
    chk("t6_norec", q_addr.size(), 32'd0);
    chk("t6_trunc", {31'd0, trunc}, 32'd0);
    send_nib(1'b0, 4'h1);
    send_nib(1'b1, 4'h5);
    send_nib(1'b1, 4'hA);
    cyc(10);
    pop_chk("t6_post", 2'd0, 2'd1, 32'h0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_btm_rx.md
Name: aud_btm_rx

Overview:
- Receive-side capture stage for AUD Branch Trace Mode. Sits downstream of the AUD pins in BTM mode and upstream of the trace FIFO.
- Oversamples AUDCK, AUDATA and AUDSYNC# in clk_sys_i and deframes the nibble stream into branch-trace messages.
- Presents each message as one record on a valid/ready interface into the FIFO writer, with overflow accounting.

Parameters:
- g_sync_stages, 2, synchronizer flops on aud_ck_i/aud_data_i/aud_nsync_i (min 2).
- g_drop_cnt_w, 16, width of dropped-message counter.

Ports:
- clk_sys_i  in  1  system clock (single clock domain)
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  capture enable (tied to BTM mode select); low = flush to IDLE
- aud_ck_i  in  1  AUDCK pin, asynchronous
- aud_data_i  in  4  AUDATA pins, asynchronous
- aud_nsync_i  in  1  AUDSYNC# pin, active-low frame marker
- msg_valid_o  out  1  message record valid
- msg_ready_i  in  1  downstream accepts record
- msg_type_o  out  2  header[3:2]
- msg_size_o  out  2  header[1:0] address-size code
- msg_addr_o  out  32  assembled address, zero-extended
- ovf_o  out  1  sticky: at least one message dropped
- ovf_clr_i  in  1  clears ovf_o and drop_cnt_o
- drop_cnt_o  out  g_drop_cnt_w  dropped-message count, saturating
- trunc_o  out  1  sticky: frame aborted by early AUDSYNC#; cleared by ovf_clr_i
- idle_o  out  1  high in IDLE with no pending record

Behaviour:
- Reset (async, rst_n_i=0): all synchronizer flops 1 except data=0; state IDLE; msg_valid_o=0, msg_type_o=0, msg_size_o=0, msg_addr_o=0, ovf_o=0, trunc_o=0, drop_cnt_o=0, idle_o=1.
- Sampling:
  - All three pin groups pass through g_sync_stages flops plus one history flop.
  - Event E = synced aud_ck rising (prev 0, cur 1).
  - Data and nsync are taken from the same synced stage as the ck value that produced E.
  - Pin-to-E latency: g_sync_stages+1 cycles.
- Frame format:
  - Header nibble: nsync=0 at E. header[3:2]=type, header[1:0]=size code.
  - Size code to nibble count N: 00->1, 01->2, 10->4, 11->8.
  - Address nibbles: nsync=1 at E, least-significant nibble first.
- FSM:
  - IDLE: on E with nsync=0, latch header, clear addr shift reg, nib_cnt=0, go DATA. E with nsync=1 is ignored.
  - DATA: on E with nsync=1, write nibble into addr[4*nib_cnt+:4] and increment nib_cnt. When nib_cnt reaches N, the frame is complete: go to IDLE and issue the record.
  - DATA, E with nsync=0 (early header): set trunc_o, discard partial frame, latch the new header, stay in DATA with nib_cnt=0.
- Output register (single entry):
  - Record issued on the cycle after the completing E. msg_valid_o rises the cycle after the last nibble's E.
  - Record held stable until msg_valid_o & msg_ready_i.
  - Completion while valid & !ready: new record dropped, ovf_o=1, drop_cnt_o+1 saturating at all-ones.
  - Completion while valid & ready in the same cycle: new record loads, valid stays 1, no drop.
- en_i=0: FSM forced to IDLE, partial frame discarded without setting trunc_o, sampling continues. A pending record stays until accepted.
- ovf_clr_i coinciding with a drop: the drop wins (ovf_o=1, drop_cnt_o=1).
- idle_o = (state==IDLE) & !msg_valid_o.
- Throughput: one nibble per E. Requires AUDCK high and low phases each >= 2 clk_sys_i periods; faster clocks are unspecified.

Optional Feature:
- AUD_BTM_RX_TSTAMP_EN defined:
  - Adds a free-running 32-bit cycle counter, reset 0, wrapping.
  - The counter value is captured at the header's E (including a restart header).
  - Presented on msg_tstamp_o[31:0] with the same valid/hold rules as the other record fields.
- Not defined: port absent, no counter logic.

Decomposition:
- Shared package aud_defs holds:
  - size-code constants and the N lookup (AUD_BTM_SZ_4B etc.)
  - type codes
  - FSM state encoding
- One natural sub-module, aud_pin_sync: parameterized multi-bit synchronizer with edge detect, reusable by the RMM receive path.

Test Plan:
- Header 0x3 (type 0, size 11) then nibbles 1,2,3,4,5,6,7,8, ready=1 -> one record: type=0, size=3, addr=0x87654321; valid high exactly 1 cycle; idle_o returns to 1.
- Header 0x4 (type 1, size 00), nibble 0xA, ready=0 -> record addr=0x0000000A held. Second frame completes -> drop_cnt_o=1, ovf_o=1, first record unchanged. Pulse ovf_clr_i -> both 0.
- Header 0x2 (size 10), 2 nibbles, then a new header 0x1 with nsync=0 followed by 0xF,0xE -> trunc_o=1, only one record issued: size=1, addr=0x000000EF.
- Record pending, ready=1 on the cycle the next frame completes -> both records delivered, drop_cnt_o=0.
- Assert rst_n_i low mid-DATA, asynchronously -> all outputs at reset values immediately. After release, a new 1-nibble frame decodes correctly.
- en_i=0 during a frame, then en_i=1 and stream AUDCK nibbles without a header -> no record, trunc_o=0. A full frame afterwards decodes correctly.
